// File: rtl/sync_bridge.sv
`timescale 1ns/1ps
// sync_bridge: clkb->clka request crossing (toggle + edge detect) and a
// gray-pointer asynchronous FIFO carrying the producer's burst back to clkb.

module sync_bridge_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst_out
);
    logic [STAGES-1:0] rst_r;

    // Assert asynchronously, release only after STAGES clean clock edges
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rst_r <= '1;
        end else begin
            rst_r <= {rst_r[STAGES-2:0], 1'b0};
        end
    end

    assign rst_out = rst_r[STAGES-1];
endmodule

module sync_bridge_vec_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage_r [STAGES];

    // Flop chain; safe for vectors only because callers feed single-bit-change codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];
endmodule

module sync_bridge #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clka,
    input  logic              clkb,
    input  logic              resetb_clkb,
    input  logic [DATA_W-1:0] din_clka,
    input  logic              data_valid_clka,
    output logic              data_req_clka,
    input  logic              data_req_clkb,
    output logic              data_valid_clkb,
    output logic [DATA_W-1:0] dout_clkb
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic              rst_a_s;
    logic              rst_b_s;

    logic              req_tog_r;
    logic              req_sync_s;
    logic              req_prev_r;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wbin_r;
    logic [PTR_W-1:0]  wgray_r;
    logic              full_r;
    logic              write_s;
    logic [PTR_W-1:0]  wbin_next_s;
    logic [PTR_W-1:0]  wgray_next_s;
    logic              full_next_s;
    logic [PTR_W-1:0]  rgray_sync_s;

    logic [PTR_W-1:0]  rbin_r;
    logic [PTR_W-1:0]  rgray_r;
    logic              empty_r;
    logic              read_s;
    logic [PTR_W-1:0]  rbin_next_s;
    logic [PTR_W-1:0]  rgray_next_s;
    logic              empty_next_s;
    logic [PTR_W-1:0]  wgray_sync_s;

    sync_bridge_rst_sync #(.STAGES(SYNC_STAGES)) u_rst_a (
        .clk     (clka),
        .rst_in  (resetb_clkb),
        .rst_out (rst_a_s)
    );

    sync_bridge_rst_sync #(.STAGES(SYNC_STAGES)) u_rst_b (
        .clk     (clkb),
        .rst_in  (resetb_clkb),
        .rst_out (rst_b_s)
    );

    // Each clkb request cycle flips the toggle; clka sees the flip as an edge
    always_ff @(posedge clkb or posedge rst_b_s) begin
        if (rst_b_s) begin
            req_tog_r <= 1'b0;
        end else if (data_req_clkb) begin
            req_tog_r <= ~req_tog_r;
        end
    end

    sync_bridge_vec_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clka),
        .rst (rst_a_s),
        .d   (req_tog_r),
        .q   (req_sync_s)
    );

    // Edge detect on the synchronized toggle gives a one-cycle clka pulse
    always_ff @(posedge clka or posedge rst_a_s) begin
        if (rst_a_s) begin
            req_prev_r    <= 1'b0;
            data_req_clka <= 1'b0;
        end else begin
            req_prev_r    <= req_sync_s;
            data_req_clka <= req_sync_s ^ req_prev_r;
        end
    end

    sync_bridge_vec_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk (clka),
        .rst (rst_a_s),
        .d   (rgray_r),
        .q   (rgray_sync_s)
    );

    // Write pointer advance and full test against the synchronized read pointer
    always_comb begin
        write_s      = data_valid_clka & ~full_r;
        wbin_next_s  = wbin_r + {{ADDR_W{1'b0}}, write_s};
        wgray_next_s = bin2gray(wbin_next_s);
        full_next_s  = (wgray_next_s == {~rgray_sync_s[PTR_W-1:PTR_W-2],
                                          rgray_sync_s[PTR_W-3:0]});
    end

    // Write-side pointer and full registers
    always_ff @(posedge clka or posedge rst_a_s) begin
        if (rst_a_s) begin
            wbin_r  <= '0;
            wgray_r <= '0;
            full_r  <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wgray_r <= wgray_next_s;
            full_r  <= full_next_s;
        end
    end

    // Storage is not reset; pointer reset alone discards its contents
    always_ff @(posedge clka) begin
        if (write_s) begin
            mem_r[wbin_r[ADDR_W-1:0]] <= din_clka;
        end
    end

    sync_bridge_vec_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk (clkb),
        .rst (rst_b_s),
        .d   (wgray_r),
        .q   (wgray_sync_s)
    );

    // Read whenever not empty; empty compares against the synchronized write pointer
    always_comb begin
        read_s       = ~empty_r;
        rbin_next_s  = rbin_r + {{ADDR_W{1'b0}}, read_s};
        rgray_next_s = bin2gray(rbin_next_s);
        empty_next_s = (rgray_next_s == wgray_sync_s);
    end

    // Read-side pointer, empty flag and registered outputs
    always_ff @(posedge clkb or posedge rst_b_s) begin
        if (rst_b_s) begin
            rbin_r          <= '0;
            rgray_r         <= '0;
            empty_r         <= 1'b1;
            data_valid_clkb <= 1'b0;
            dout_clkb       <= '0;
        end else begin
            rbin_r          <= rbin_next_s;
            rgray_r         <= rgray_next_s;
            empty_r         <= empty_next_s;
            data_valid_clkb <= read_s;
            if (read_s) begin
                dout_clkb <= mem_r[rbin_r[ADDR_W-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_sync_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for sync_bridge: request latency/pulse counting on clka,
// a byte scoreboard on clkb, vector table plus reset/overflow sequences.

module tb_sync_bridge;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 5;
    localparam int SYNC_STAGES = 2;

    logic              clka            = 1'b0;
    logic              clkb            = 1'b0;
    logic              resetb_clkb     = 1'b0;
    logic [DATA_W-1:0] din_clka        = '0;
    logic              data_valid_clka = 1'b0;
    logic              data_req_clkb   = 1'b0;
    logic              data_req_clka;
    logic              data_valid_clkb;
    logic [DATA_W-1:0] dout_clkb;

    sync_bridge #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clka            (clka),
        .clkb            (clkb),
        .resetb_clkb     (resetb_clkb),
        .din_clka        (din_clka),
        .data_valid_clka (data_valid_clka),
        .data_req_clka   (data_req_clka),
        .data_req_clkb   (data_req_clkb),
        .data_valid_clkb (data_valid_clkb),
        .dout_clkb       (dout_clkb)
    );

    always #6.25 clka = ~clka;
    always #10   clkb = ~clkb;

    typedef struct {
        int n_req;
        int req_gap;
        int n_words;
        int exp_pulses;
        int exp_words;
        bit gapless;
    } vec_t;

    vec_t vecs[4];

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;
    int runs      = 0;
    int pulses    = 0;
    int width_err = 0;
    int ovf_last  = -1;
    bit ovf_mode  = 1'b0;
    bit valid_prev = 1'b0;
    bit req_prev   = 1'b0;
    logic [DATA_W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Consumer-side scoreboard: every valid byte must match the next expected one
    always @(negedge clkb) begin
        if (data_valid_clkb === 1'b1) begin
            delivered++;
            if (!valid_prev) runs++;
            if (ovf_mode) begin
                check_range("ovf_order", int'(dout_clkb), ovf_last + 1, 99);
                ovf_last = int'(dout_clkb);
            end else if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %0d, expected no valid", dout_clkb);
            end else begin
                check("dout_order", {24'd0, dout_clkb}, {24'd0, sb_q.pop_front()});
            end
        end
        valid_prev = (data_valid_clkb === 1'b1);
    end

    // Producer-side pulse counter; a pulse wider than one cycle is an error
    always @(negedge clka) begin
        if (data_req_clka === 1'b1) begin
            if (req_prev) width_err++;
            else pulses++;
        end
        req_prev = (data_req_clka === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_req();
        @(negedge clkb);
        data_req_clkb = 1'b1;
        @(negedge clkb);
        data_req_clkb = 1'b0;
    endtask

    task automatic write_burst(input int n, input bit idx_data);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] v;
            @(negedge clka);
            v = idx_data ? 8'(i) : 8'($urandom_range(0, 255));
            din_clka        = v;
            data_valid_clka = 1'b1;
            if (!ovf_mode) sb_q.push_back(v);
        end
        @(negedge clka);
        data_valid_clka = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input string name);
        int k = 0;
        while (pulses < target && k < 40) begin
            @(negedge clka);
            k++;
        end
        repeat (2) @(negedge clka);
        check(name, pulses, target);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || data_valid_clkb === 1'b1) && k < 400) begin
            @(negedge clkb);
            k++;
        end
        repeat (10) @(negedge clkb);
        check({name, "_drained"}, sb_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int p0 = pulses;
        int d0 = delivered;
        for (int r = 0; r < v.n_req; r++) begin
            send_req();
            if (r < v.n_req - 1) repeat (v.req_gap - 2) @(negedge clkb);
        end
        wait_pulses(p0 + v.exp_pulses, $sformatf("v%0d_pulses", idx));
        runs = 0;
        write_burst(v.n_words, 1'b0);
        wait_drain($sformatf("v%0d", idx));
        check($sformatf("v%0d_words", idx), delivered - d0, v.exp_words);
        if (v.gapless) check($sformatf("v%0d_runs", idx), runs, 1);
    endtask

    initial begin
        int p0;
        int d0;
        int lat;
        bit found;

        vecs[0] = '{n_req: 1, req_gap: 0, n_words: 20, exp_pulses: 1, exp_words: 20, gapless: 1'b1};
        vecs[1] = '{n_req: 2, req_gap: 6, n_words: 5,  exp_pulses: 2, exp_words: 5,  gapless: 1'b0};
        vecs[2] = '{n_req: 1, req_gap: 0, n_words: 1,  exp_pulses: 1, exp_words: 1,  gapless: 1'b1};
        vecs[3] = '{n_req: 3, req_gap: 4, n_words: 32, exp_pulses: 3, exp_words: 32, gapless: 1'b0};

        // Reset held with clocks running
        #1 resetb_clkb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkb);
            check("rst_req", data_req_clka, 0);
            check("rst_valid", data_valid_clkb, 0);
            check("rst_dout", dout_clkb, 0);
        end
        resetb_clkb = 1'b0;
        repeat (20) @(negedge clkb);
        check("idle_pulses", pulses, 0);
        check("idle_words", delivered, 0);

        // Single request near 1 us: latency measured from the toggle-flip edge
        while ($time < 1000) @(negedge clkb);
        @(negedge clkb);
        p0 = pulses;
        data_req_clkb = 1'b1;
        @(posedge clkb);
        fork
            begin
                @(negedge clkb);
                data_req_clkb = 1'b0;
            end
        join_none
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 8 && !found; k++) begin
            @(posedge clka);
            #1;
            if (data_req_clka === 1'b1) begin
                lat   = k;
                found = 1'b1;
            end
        end
        check_range("req_latency", lat, 3, 4);
        repeat (10) @(negedge clka);
        check("req_single_pulse", pulses - p0, 1);
        d0 = delivered;
        runs = 0;
        write_burst(20, 1'b0);
        wait_drain("burst20");
        check("burst20_words", delivered - d0, 20);
        check("burst20_runs", runs, 1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Overflow: 100 back-to-back writes, delivered must be an ordered subsequence
        send_req();
        wait_pulses(pulses + 1, "ovf_pulse");
        ovf_mode = 1'b1;
        ovf_last = -1;
        d0 = delivered;
        write_burst(100, 1'b1);
        repeat (300) @(negedge clkb);
        ovf_mode = 1'b0;
        check_range("ovf_delivered", delivered - d0, 33, 99);
        check("ovf_idle_valid", data_valid_clkb, 0);

        // Reset mid-burst: valid drops at once, nothing stale afterwards
        send_req();
        wait_pulses(pulses + 1, "mid_pulse");
        write_burst(10, 1'b0);
        @(posedge clkb);
        #2 resetb_clkb = 1'b1;
        #1;
        check("mid_rst_valid", data_valid_clkb, 0);
        check("mid_rst_dout", dout_clkb, 0);
        sb_q.delete();
        d0 = delivered;
        p0 = pulses;
        repeat (5) @(negedge clkb);
        resetb_clkb = 1'b0;
        repeat (40) @(negedge clkb);
        check("mid_no_stale", delivered - d0, 0);
        check("mid_no_spurious_req", pulses - p0, 0);

        run_vec(vecs[0], 9);

        check("req_width", width_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
